// File: rtl/audio_app_prgrm_tx_if.sv
// Interface for the audio_app programming transmitter: control-side word
// handshake, audio_app serial pins and status pulses.
interface audio_app_prgrm_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              prgrm_in;
  logic              prgrm_go_;
  logic              err_;
  logic              busy;
  logic              done;
  logic              fail;

  modport master (
    output cfg_data, cfg_valid, err_,
    input  cfg_ready, prgrm_in, prgrm_go_, busy, done, fail
  );

  modport slave (
    input  cfg_data, cfg_valid, err_,
    output cfg_ready, prgrm_in, prgrm_go_, busy, done, fail
  );
endinterface

// File: rtl/audio_app_prgrm_tx.sv
// Serializes a routing word MSB-first to audio_app, strobes prgrm_go_, watches err_
// and retries. Define PRGRM_PARITY_EN to append an even-parity bit after the LSB.
module audio_app_prgrm_tx #(
  parameter int DATA_W    = 8,
  parameter int ERR_WIN   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                clk,
  input  logic                rst_,
  audio_app_prgrm_tx_if.slave bus
);

`ifdef PRGRM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_W = DATA_W + PAR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int WIN_W   = $clog2(ERR_WIN + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, GO, CHECK} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  hold_q;
  logic [FRAME_W-1:0] shift_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [RTY_W-1:0]   retry_cnt_q;
  logic               err_seen_q;

  logic               accept, retry, pass, give_up;
  logic [DATA_W-1:0]  load_word;
  logic [FRAME_W-1:0] load_frame;

  logic prgrm_in_q, prgrm_go_n_q, cfg_ready_q, busy_q, done_q, fail_q;
  logic prgrm_in_d, prgrm_go_n_d, busy_d;

  // A retry resends the held word; only a fresh accept looks at cfg_data.
  assign load_word = (state_q == IDLE) ? bus.cfg_data : hold_q;
`ifdef PRGRM_PARITY_EN
  assign load_frame = {load_word, ^load_word};
`else
  assign load_frame = load_word;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    retry   = 1'b0;
    pass    = 1'b0;
    give_up = 1'b0;
    unique case (state_q)
      IDLE: if (bus.cfg_valid) begin
        accept  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (bit_cnt_q == CNT_W'(FRAME_W - 1)) state_d = GO;
      GO:    state_d = CHECK;
      CHECK: if (win_cnt_q == WIN_W'(ERR_WIN - 1)) begin
        // The final window sample is folded in directly rather than via err_seen_q.
        if (!err_seen_q && bus.err_) begin
          pass    = 1'b1;
          state_d = IDLE;
        end else if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
          retry   = 1'b1;
          state_d = SHIFT;
        end else begin
          give_up = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prgrm_in_d = 1'b0;
    if (accept || retry)                           prgrm_in_d = load_frame[FRAME_W-1];
    else if (state_q == SHIFT && state_d == SHIFT) prgrm_in_d = shift_q[FRAME_W-1];
    prgrm_go_n_d = (state_d != GO);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      hold_q       <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      win_cnt_q    <= '0;
      retry_cnt_q  <= '0;
      err_seen_q   <= 1'b0;
      prgrm_in_q   <= 1'b0;
      prgrm_go_n_q <= 1'b1;
      cfg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      prgrm_in_q   <= prgrm_in_d;
      prgrm_go_n_q <= prgrm_go_n_d;
      busy_q       <= busy_d;
      cfg_ready_q  <= ~busy_d;
      done_q       <= pass;
      fail_q       <= give_up;

      if (accept) begin
        hold_q      <= bus.cfg_data;
        retry_cnt_q <= '0;
      end else if (retry) begin
        retry_cnt_q <= retry_cnt_q + 1'b1;
      end

      // shift_q[MSB] is always the next bit to drive onto prgrm_in.
      if (accept || retry) begin
        shift_q   <= load_frame << 1;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        shift_q   <= shift_q << 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (state_q == GO) begin
        win_cnt_q  <= '0;
        err_seen_q <= 1'b0;
      end else if (state_q == CHECK) begin
        win_cnt_q  <= win_cnt_q + 1'b1;
        err_seen_q <= err_seen_q | ~bus.err_;
      end
    end
  end

  assign bus.prgrm_in  = prgrm_in_q;
  assign bus.prgrm_go_ = prgrm_go_n_q;
  assign bus.cfg_ready = cfg_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;

endmodule
